id_exe_stage_reg: RTL
=====================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the ID stage and the EXE stage of the ARM core.
- Captures decoded controls, operand values, shift operand and status flags.
- Presents them to EXE: Val2 generation, ALU, branch-target adder.
- Implements freeze (SRAM/hazard stall) and flush (taken branch); keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, operand and PC width
- REG_W, 4, register-index width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- freeze  in  1  hold all contents (SRAM wait or hazard stall)
- flush  in  1  taken branch in EXE; replace incoming instruction with bubble
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC+4 of ID instruction
- id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s, id_imm  in  1 each  decoded controls
- id_exe_cmd  in  4  ALU command
- id_shift_operand  in  12  instr[11:0]
- id_signed_imm_24  in  24  branch offset
- id_dest, id_src1, id_src2  in  REG_W  register indices
- id_val_rn, id_val_rm  in  DATA_W  register-file read data
- id_sr  in  4  NZCV from status register
- exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s, exe_imm  out  1 each  registered controls
- exe_memrw  out  1  registered (id_mem_r_en | id_mem_w_en); drives Val2 memrw select
- exe_exe_cmd  out  4
- exe_shift_operand  out  12
- exe_signed_imm_24  out  24
- exe_dest, exe_src1, exe_src2  out  REG_W
- exe_pc, exe_val_rn, exe_val_rm  out  DATA_W
- exe_sr  out  4  carry source for ALU (C = exe_sr[1])
- bubble_cnt  out  CNT_W  saturating count of bubbles loaded

Behaviour:
- Reset (rst=0, asynchronous, any time): every output goes to 0, including bubble_cnt. Takes effect immediately, mid-stall included. The first load happens on the first rising edge after rst=1.
- Latency: 1 cycle from id_* to exe_* when not frozen.
- Each rising edge applies exactly one of the following, in priority order:
  1. freeze=1: hold every register, bubble_cnt included. Freeze beats flush: the branch causing the flush is itself stalled in EXE and re-asserts flush once freeze drops.
  2. flush=1: load a bubble.
  3. id_valid=0: load a bubble.
  4. Otherwise: load every exe_* field from the matching id_* field; exe_valid=1; exe_memrw=id_mem_r_en|id_mem_w_en.
- Bubble contents:
  - exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_memrw, exe_b, exe_s = 0.
  - exe_exe_cmd=0, exe_imm=0, exe_shift_operand=0, exe_dest/src1/src2=0, exe_val_rn/rm=0, exe_signed_imm_24=0, exe_pc=0.
  - exe_sr still loads id_sr, so flags stay current for the next real instruction.
- bubble_cnt increments by 1 on each non-frozen edge that loads a bubble (flush, or id_valid=0). It saturates at all-ones and never wraps.
- Invariants:
  - exe_valid=0 implies no wb/mem/b/s side-effect bits set.
  - Simultaneous id_mem_r_en and id_mem_w_en pass through unchanged; no checking is done here.
- No combinational path from any id_* input to any exe_* output.

Decomposition:
- Shared package arm_pkg holds:
  - EXE_CMD encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP/SUB, TST/AND, LDR/STR = ADD).
  - SR bit positions N=3, Z=2, C=1, V=0.
  - Widths DATA_W and REG_W.
- One natural sub-module: pipe_field_reg. It is a parameterised-width register with enable (=~freeze), a synchronous clear value (for flush/bubble) and asynchronous active-low reset. It is instantiated per field group: control, data, index.
- bubble_cnt lives in the top level.

Test Plan:
- Reset: hold rst=0 with id_* all-ones, then release → all exe_* = 0 and bubble_cnt=0. Assert rst=0 asynchronously between edges while exe_valid=1 → outputs clear before the next edge.
- Normal load: id_valid=1, id_val_rm=0x8000_0001, id_shift_operand=0x0E3, id_imm=0, id_mem_r_en=1, id_dest=5 → one edge later exe_val_rm=0x8000_0001, exe_shift_operand=0x0E3, exe_memrw=1, exe_dest=5, exe_valid=1.
- Flush: exe holds ADD (wb_en=1); assert flush=1 with id_valid=1, id_wb_en=1, id_sr=4'b0010 → next edge exe_valid=0, exe_wb_en=0, exe_sr=4'b0010, bubble_cnt=1.
- Freeze over flush: freeze=1 and flush=1 for 3 edges while id_* changes → exe_* and bubble_cnt unchanged. Drop freeze with flush=1 → bubble loaded on that edge.
- Bubble from ID: id_valid=0 for 5 edges → bubble_cnt=5, exe_valid=0 throughout. Then id_valid=1 → exe_valid=1, count stays 5.
- Saturation: with CNT_W=4, drive 20 consecutive bubbles → bubble_cnt goes 1…15 and stays 15.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM core widths, ALU command encodings and status-register bit positions.
package arm_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    typedef enum logic [3:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    // Compare/test and memory instructions reuse the arithmetic encodings.
    localparam exe_cmd_e CMD_CMP = CMD_SUB;
    localparam exe_cmd_e CMD_TST = CMD_AND;
    localparam exe_cmd_e CMD_LDR = CMD_ADD;
    localparam exe_cmd_e CMD_STR = CMD_ADD;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;
endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: pipeline field register with hold enable, synchronous clear and async active-low reset.
module pipe_field_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            q <= '0;
        else if (en)
            q <= clr ? '0 : d;
endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID/EXE pipeline register with freeze, flush-to-bubble and a saturating bubble counter.
module id_exe_stage_reg #(
    parameter int DATA_W = arm_pkg::DATA_W,
    parameter int REG_W  = arm_pkg::REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic              id_imm,
    input  logic [3:0]        id_exe_cmd,
    input  logic [11:0]       id_shift_operand,
    input  logic [23:0]       id_signed_imm_24,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [3:0]        id_sr,
    output logic              exe_valid,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_memrw,
    output logic              exe_b,
    output logic              exe_s,
    output logic              exe_imm,
    output logic [3:0]        exe_exe_cmd,
    output logic [11:0]       exe_shift_operand,
    output logic [23:0]       exe_signed_imm_24,
    output logic [REG_W-1:0]  exe_dest,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic [3:0]        exe_sr,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int DW = 3*DATA_W + 36;

    logic          en, bub;
    logic [11:0]   ctrl_d, ctrl_q;
    logic [DW-1:0] data_d, data_q;
    logic [3*REG_W-1:0] idx_d, idx_q;

    assign en  = ~freeze;
    assign bub = flush | ~id_valid;

    assign ctrl_d = {1'b1, id_wb_en, id_mem_r_en, id_mem_w_en, id_mem_r_en | id_mem_w_en,
                     id_b, id_s, id_imm, id_exe_cmd};
    assign data_d = {id_pc, id_val_rn, id_val_rm, id_shift_operand, id_signed_imm_24};
    assign idx_d  = {id_dest, id_src1, id_src2};

    assign {exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_memrw,
            exe_b, exe_s, exe_imm, exe_exe_cmd} = ctrl_q;
    assign {exe_pc, exe_val_rn, exe_val_rm, exe_shift_operand, exe_signed_imm_24} = data_q;
    assign {exe_dest, exe_src1, exe_src2} = idx_q;

    pipe_field_reg #(.W(12))      u_ctrl (.clk(clk), .rst(rst), .en(en), .clr(bub),  .d(ctrl_d), .q(ctrl_q));
    pipe_field_reg #(.W(DW))      u_data (.clk(clk), .rst(rst), .en(en), .clr(bub),  .d(data_d), .q(data_q));
    pipe_field_reg #(.W(3*REG_W)) u_idx  (.clk(clk), .rst(rst), .en(en), .clr(bub),  .d(idx_d),  .q(idx_q));
    // Flags load even on bubbles so the next real instruction sees current NZCV.
    pipe_field_reg #(.W(4))       u_sr   (.clk(clk), .rst(rst), .en(en), .clr(1'b0), .d(id_sr),  .q(exe_sr));

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            bubble_cnt <= '0;
        else if (en && bub && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + 1'b1;
endmodule
